// File: rtl/digit_frame_arbiter.sv
// Round-robin arbiter sharing one 1-0-9-4 sequence detector between two
// four-digit requesters; flushes the detector between frames and returns a verdict.
//
// state | meaning
// INIT  | one flush cycle after reset; detector has no reset of its own
// IDLE  | sample requests, arbitrate, emit previous frame's done/match
// FEED  | steer granted digits onto the detector, counter 0..FRAME_LEN-1
// CHECK | flush detector, latch verdict for the owner

module digit_frame_arbiter #(
  parameter int         FRAME_LEN   = 4,
  parameter logic [3:0] FLUSH_DIGIT = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] num_a,
  input  logic [3:0] num_b,
  input  logic       det_pattern,
  output logic [3:0] det_number,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic       match,
  output logic       busy
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_FEED  = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_gnt;
  logic             first_is_one;

  logic             any_req;
  logic             pick_b;
  logic [3:0]       fed_digit;
  logic             verdict;

  always_comb begin
    any_req = req_a | req_b;
    // On a tie the requester not served last wins.
    if (req_a && req_b) pick_b = (last_gnt == OWN_A);
    else                pick_b = req_b;
  end

  always_comb begin
    fed_digit  = (owner == OWN_B) ? num_b : num_a;
    det_number = (state == S_FEED) ? fed_digit : FLUSH_DIGIT;
  end

  // The detector only clears pattern on a leading 1, so a stale 1 from an
  // earlier matching frame is masked unless this frame also started with 1.
  assign verdict = det_pattern & first_is_one;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_INIT;
      cnt          <= '0;
      owner        <= OWN_A;
      last_gnt     <= OWN_B;
      first_is_one <= 1'b0;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      done_a       <= 1'b0;
      done_b       <= 1'b0;
      match        <= 1'b0;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      match  <= 1'b0;
      case (state)
        S_INIT: begin
          state <= S_IDLE;
        end
        S_IDLE: begin
          if (any_req) begin
            state <= S_FEED;
            owner <= pick_b;
            gnt_a <= ~pick_b;
            gnt_b <= pick_b;
            cnt   <= '0;
          end
        end
        S_FEED: begin
          if (cnt == '0) first_is_one <= (fed_digit == 4'd1);
          if (cnt == CNT_LAST) begin
            state <= S_CHECK;
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CHECK: begin
          done_a   <= (owner == OWN_A);
          done_b   <= (owner == OWN_B);
          match    <= verdict;
          last_gnt <= owner;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_frame_arbiter.sv
// Directed bench for digit_frame_arbiter with a behavioural 1-0-9-4 detector
// (no reset, sticky pattern) and a verdict scoreboard.

module tb_digit_frame_arbiter;

  logic       clock;
  logic       reset;
  logic       req_a, req_b;
  logic [3:0] num_a, num_b;
  logic       det_pattern;
  logic [3:0] det_number;
  logic       gnt_a, gnt_b, done_a, done_b, match, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic who;
    logic m;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic pat_in_check;

  digit_frame_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req_a       (req_a),
    .req_b       (req_b),
    .num_a       (num_a),
    .num_b       (num_b),
    .det_pattern (det_pattern),
    .det_number  (det_number),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .done_a      (done_a),
    .done_b      (done_b),
    .match       (match),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Detector model: starts mid-sequence with a stale pattern to exercise INIT flush.
  logic [1:0] dstate;
  initial begin
    dstate      = 2'd2;
    det_pattern = 1'b1;
  end
  always @(posedge clock) begin
    case (dstate)
      2'd0: if (det_number == 4'd1) begin dstate <= 2'd1; det_pattern <= 1'b0; end
      2'd1: if (det_number == 4'd0) dstate <= 2'd2;
            else if (det_number == 4'd1) dstate <= 2'd1;
            else dstate <= 2'd0;
      2'd2: if (det_number == 4'd9) dstate <= 2'd3;
            else if (det_number == 4'd1) begin dstate <= 2'd1; det_pattern <= 1'b0; end
            else dstate <= 2'd0;
      default: if (det_number == 4'd4) begin dstate <= 2'd0; det_pattern <= 1'b1; end
            else if (det_number == 4'd1) begin dstate <= 2'd1; det_pattern <= 1'b0; end
            else dstate <= 2'd0;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_and_check(input logic who_seen);
    if (sb.size() == 0) begin
      check("sb_unexpected_done", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check("done_owner", who_seen, e.who);
      check("match", match, e.m);
    end
  endtask

  // Sends one frame from an idle arbiter, starting at a negedge.
  task automatic frame(input logic who, input logic [15:0] digits);
    int waited;
    logic [3:0] d;
    sb.push_back(exp_t'({who, (digits == 16'h1094)}));
    if (who) req_b = 1'b1; else req_a = 1'b1;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!(who ? gnt_b : gnt_a) && waited < 10);
    check("grant_latency", 16'(waited), 16'd1);
    req_a = 1'b0;
    req_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = digits[15-4*k -: 4];
      if (who) num_b = d; else num_a = d;
      #1;
      check("gnt_own", who ? gnt_b : gnt_a, 1'b1);
      check("gnt_other", who ? gnt_a : gnt_b, 1'b0);
      check("det_number_feed", det_number, d);
      @(negedge clock);
    end
    check("gnt_drop", gnt_a | gnt_b, 1'b0);
    check("det_number_check", det_number, 4'hF);
    check("busy_check", busy, 1'b1);
    check("done_early", done_a | done_b, 1'b0);
    pat_in_check = det_pattern;
    if (who) num_b = 4'd1; else num_a = 4'd1;
    @(negedge clock);
    check("done_own", who ? done_b : done_a, 1'b1);
    check("done_other", who ? done_a : done_b, 1'b0);
    check("busy_done", busy, 1'b0);
    check("det_number_idle", det_number, 4'hF);
    pop_and_check(done_b);
    @(negedge clock);
    check("done_pulse", done_a | done_b | match, 1'b0);
  endtask

  initial begin : stim
    int starts, dones, cyc, last_start, low_run, pos;
    logic pa, pb, exp_who;

    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    num_a = 4'd1;
    num_b = 4'd1;
    repeat (2) @(negedge clock);
    check("rst_gnt", {gnt_a, gnt_b}, 2'b00);
    check("rst_done", {done_a, done_b}, 2'b00);
    check("rst_match", match, 1'b0);
    check("rst_det_number", det_number, 4'hF);
    check("rst_busy", busy, 1'b1);
    reset = 1'b0;
    #1 check("init_busy", busy, 1'b1);
    @(negedge clock);
    check("idle_busy", busy, 1'b0);

    // Basic match, mismatch on B, stale pattern, partial-frame flush.
    frame(1'b0, 16'h1094);
    frame(1'b1, 16'h1095);
    frame(1'b0, 16'h1094);
    frame(1'b0, 16'h3333);
    check("stale_pattern_seen", pat_in_check, 1'b1);
    frame(1'b0, 16'h5510);
    frame(1'b1, 16'h1094);

    // Both requests held: A sends 1094 (match), B sends 1095 (no match).
    starts = 0; dones = 0; cyc = 0; last_start = 0; low_run = 0; pos = 0;
    pa = 1'b0; pb = 1'b0; exp_who = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    while (dones < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if ((gnt_a && !pa) || (gnt_b && !pb)) begin
        starts++;
        pos = 0;
        check("rr_order", gnt_b, exp_who);
        sb.push_back(exp_t'({gnt_b, ~gnt_b}));
        if (starts > 1) check("start_spacing", 16'(cyc - last_start), 16'd6);
        last_start = cyc;
        exp_who = ~exp_who;
        if (starts == 4) begin req_a = 1'b0; req_b = 1'b0; end
      end
      if (gnt_a) num_a = 4'(16'h1094 >> (12 - 4*pos));
      if (gnt_b) num_b = 4'(16'h1095 >> (12 - 4*pos));
      if (gnt_a || gnt_b) pos++;
      if (!busy) low_run++;
      else begin
        if (low_run > 0 && starts > 0) check("idle_gap", 16'(low_run), 16'd1);
        low_run = 0;
      end
      if (done_a || done_b) begin
        pop_and_check(done_b);
        dones++;
      end
      pa = gnt_a;
      pb = gnt_b;
    end
    check("rr_frames_done", 16'(dones), 16'd4);
    check("rr_starts", 16'(starts), 16'd4);
    @(negedge clock);

    // Reset during FEED counter 2 aborts the frame.
    req_a = 1'b1;
    @(negedge clock);
    check("abort_gnt", gnt_a, 1'b1);
    num_a = 4'd1;
    req_a = 1'b0;
    @(negedge clock);
    num_a = 4'd0;
    @(negedge clock);
    num_a = 4'd9;
    #2 reset = 1'b1;
    #1;
    check("abort_gnt_drop", {gnt_a, gnt_b}, 2'b00);
    check("abort_done", {done_a, done_b, match}, 3'b000);
    check("abort_det_number", det_number, 4'hF);
    check("abort_busy", busy, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1 check("abort_init", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_no_done", {done_a, done_b}, 2'b00);
      check("abort_idle", busy, 1'b0);
    end
    frame(1'b0, 16'h1094);
    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
